// File: rtl/console_line_scroller_if.sv
// Interface between the console scroller and its neighbours: the line
// assembler drives start/line_push/line_data, and the char-RAM writer consumes
// the char_* stream together with busy/finish.
//
// Handshake: there is no back-pressure. start and line_push are single-cycle
// strobes, sampled on the rising clock edge. char_valid marks each cycle in
// which char_index/char_data carry a beat, and the consumer must take every
// beat as it appears. finish is a one-cycle pulse after the last beat.
interface console_line_scroller_if #(
    parameter int NUM_LINES  = 8,
    parameter int LINE_CHARS = 32,
    parameter int CHAR_W     = 8
);
    localparam int IW = $clog2(NUM_LINES * LINE_CHARS);

    logic                         start;
    logic [LINE_CHARS*CHAR_W-1:0] line_data;
    logic                         line_push;
    logic                         char_valid;
    logic [IW-1:0]                char_index;
    logic [CHAR_W-1:0]            char_data;
    logic                         busy;
    logic                         finish;
    logic [1:0]                   state_dbg;

    modport master (
        output start, line_data, line_push,
        input  char_valid, char_index, char_data, busy, finish, state_dbg
    );

    modport slave (
        input  start, line_data, line_push,
        output char_valid, char_index, char_data, busy, finish, state_dbg
    );
endinterface

// File: rtl/console_line_scroller.sv
// Scrolling text console store. Keeps NUM_LINES lines of LINE_CHARS characters
// (line 0 oldest/top, NUM_LINES-1 newest/bottom). A push scrolls every line up
// by one and inserts the new line at the bottom. A start request streams the
// first PRINT_COLS characters of each line as index/data beats, one per cycle,
// followed by a one-cycle finish pulse.
//
// While a print is running (or in its DONE cycle) storage is frozen: pushes
// are parked in a single pending slot (last one wins) and applied on the first
// IDLE cycle.
//
// Optional feature: define CONSOLE_CLEAR_EN to add a `clear` input that wipes
// storage and the pending slot. A clear seen during a print is remembered and
// applied on the first IDLE cycle, discarding any parked push.
module console_line_scroller #(
    parameter int NUM_LINES  = 8,
    parameter int LINE_CHARS = 32,
    parameter int CHAR_W     = 8,
    parameter int PRINT_COLS = 12
) (
    input logic clock,
    input logic reset,
`ifdef CONSOLE_CLEAR_EN
    input logic clear,
`endif
    console_line_scroller_if.slave bus
);
    localparam int LINE_W = LINE_CHARS * CHAR_W;
    localparam int IW     = $clog2(NUM_LINES * LINE_CHARS);
    localparam int LW     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CW     = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;

    typedef logic [NUM_LINES-1:0][LINE_W-1:0] store_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRINT = 2'd1, S_DONE = 2'd2} state_t;

    state_t              state_q;
    store_t              lines_q, lines_d;
    logic                pend_valid_q, pend_valid_d;
    logic [LINE_W-1:0]   pend_line_q, pend_line_d;
    logic                clr_pend_q, clr_pend_d;
    logic                clear_in;
    logic [LW-1:0]       line_q, nline;
    logic [CW-1:0]       col_q, ncol;
    logic                last_beat;
    logic                char_valid_q, busy_q, finish_q;
    logic [IW-1:0]       char_index_q;
    logic [CHAR_W-1:0]   char_data_q;

`ifdef CONSOLE_CLEAR_EN
    assign clear_in = clear;
`else
    assign clear_in = 1'b0;
`endif

    // Scroll: every line moves up by one, the new line enters at the bottom.
    function automatic store_t scroll(input store_t s, input logic [LINE_W-1:0] ln);
        return {ln, s[NUM_LINES-1:1]};
    endfunction

    // Column 0 sits in the most significant character of a line.
    function automatic logic [CHAR_W-1:0] char_at(input store_t s, input logic [LW-1:0] l,
                                                  input logic [CW-1:0] c);
        return s[l][(LINE_CHARS - 1 - int'(c)) * CHAR_W +: CHAR_W];
    endfunction

    function automatic logic [IW-1:0] beat_index(input logic [LW-1:0] l, input logic [CW-1:0] c);
        return IW'(l) * IW'(LINE_CHARS) + IW'(c);
    endfunction

    // Next-state storage: clear beats pending beats new push in IDLE; outside
    // IDLE storage is frozen and requests are parked.
    always_comb begin
        store_t s1;
        store_t s2;
        s1           = pend_valid_q ? scroll(lines_q, pend_line_q) : lines_q;
        s2           = bus.line_push ? scroll(s1, bus.line_data) : s1;
        lines_d      = lines_q;
        pend_valid_d = pend_valid_q;
        pend_line_d  = pend_line_q;
        clr_pend_d   = clr_pend_q;
        if (state_q == S_IDLE) begin
            pend_valid_d = 1'b0;
            if (clear_in || clr_pend_q) begin
                lines_d     = '0;
                pend_line_d = '0;
                clr_pend_d  = 1'b0;
            end else begin
                lines_d = s2;
            end
        end else begin
            if (clear_in) begin
                clr_pend_d = 1'b1;
            end
            if (bus.line_push) begin
                pend_valid_d = 1'b1;
                pend_line_d  = bus.line_data;
            end
        end
    end

    // Storage and pending-slot registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lines_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_line_q  <= '0;
            clr_pend_q   <= 1'b0;
        end else begin
            lines_q      <= lines_d;
            pend_valid_q <= pend_valid_d;
            pend_line_q  <= pend_line_d;
            clr_pend_q   <= clr_pend_d;
        end
    end

    // Position of the beat following the one currently on the outputs.
    always_comb begin
        if (col_q == CW'(PRINT_COLS - 1)) begin
            ncol  = '0;
            nline = line_q + LW'(1);
        end else begin
            ncol  = col_q + CW'(1);
            nline = line_q;
        end
    end

    assign last_beat = (line_q == LW'(NUM_LINES - 1)) && (col_q == CW'(PRINT_COLS - 1));

    // Print sequencer with registered beat outputs. The first beat reads the
    // post-push contents so a push coinciding with start is visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            col_q        <= '0;
            char_valid_q <= 1'b0;
            char_index_q <= '0;
            char_data_q  <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    finish_q <= 1'b0;
                    if (bus.start) begin
                        state_q      <= S_PRINT;
                        line_q       <= '0;
                        col_q        <= '0;
                        char_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        char_index_q <= '0;
                        char_data_q  <= char_at(lines_d, '0, '0);
                    end
                end
                S_PRINT: begin
                    if (last_beat) begin
                        state_q      <= S_DONE;
                        char_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        finish_q     <= 1'b1;
                    end else begin
                        line_q       <= nline;
                        col_q        <= ncol;
                        char_index_q <= beat_index(nline, ncol);
                        char_data_q  <= char_at(lines_q, nline, ncol);
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    finish_q <= 1'b0;
                end
                default: begin
                    state_q      <= S_IDLE;
                    char_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    finish_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.char_valid = char_valid_q;
    assign bus.char_index = char_index_q;
    assign bus.char_data  = char_data_q;
    assign bus.busy       = busy_q;
    assign bus.finish     = finish_q;
    assign bus.state_dbg  = state_q;
endmodule
